// File: rtl/mips_board_top.sv
`timescale 1ns/1ps
// Board top: debounced active-low keys drive a 32-bit result register R shown on LEDs, tubes and UART.
// Latency: key falling edge to R update is 2 + DEBOUNCE_CYCLES + 1 clocks; UART start bit 1 clock later.
// Backpressure: none on inputs; UART keeps one pending snapshot, newer requests overwrite it.
module mips_board_top #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_BITS       = 4,
  parameter int BAUD_DIV        = 16
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7,
  input  logic [7:0]  user_key,
  output logic [31:0] led_light,
  output logic [7:0]  digital_tube0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel0,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BCW = $clog2(BAUD_DIV + 1);
  localparam int SCW = SCAN_BITS + 2;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  // The receive pin has no function on this image.
  logic unused_rxd;
  assign unused_rxd = uart_rxd;

  // ---------------------------------------------------------------- keys
  logic [7:0]     sync1_q, sync1_d;
  logic [7:0]     sync2_q, sync2_d;
  logic [7:0]     stable_q, stable_d;
  logic [7:0]     hist_q, hist_d;
  logic [DCW-1:0] deb_cnt_q [8];
  logic [DCW-1:0] deb_cnt_d [8];
  logic [7:0]     press;

  // Synchronize, then accept a new level only after DEBOUNCE_CYCLES identical differing samples.
  always_comb begin
    sync1_d  = user_key;
    sync2_d  = sync1_q;
    hist_d   = stable_q;
    stable_d = stable_q;
    for (int k = 0; k < 8; k++) begin
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (deb_cnt_q[k] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[k] = sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Key pipeline state; every key reads "released" (1) out of reset.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1_q  <= 8'hFF;
      sync2_q  <= 8'hFF;
      stable_q <= 8'hFF;
      hist_q   <= 8'hFF;
      for (int k = 0; k < 8; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      hist_q   <= hist_d;
      for (int k = 0; k < 8; k++) deb_cnt_q[k] <= deb_cnt_d[k];
    end
  end

  // A press is a debounced 1->0 transition; releases produce nothing.
  assign press = hist_q & ~stable_q;

  // ---------------------------------------------------------------- command execution
  logic        cmd_vld;
  logic [2:0]  cmd_idx;
  logic [31:0] a_op, b_op;
  logic [31:0] r_q, r_d;
  logic [3:0]  op_q, op_d;

  assign a_op = ~{dip_switch3, dip_switch2, dip_switch1, dip_switch0};
  assign b_op = ~{dip_switch7, dip_switch6, dip_switch5, dip_switch4};

  // Pick the lowest-index press; scanning downward lets the lowest index overwrite the rest.
  always_comb begin
    cmd_vld = 1'b0;
    cmd_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (press[k]) begin
        cmd_vld = 1'b1;
        cmd_idx = 3'(k);
      end
    end
  end

  // Execute the selected command on R with operands sampled this cycle.
  always_comb begin
    r_d  = r_q;
    op_d = op_q;
    if (cmd_vld) begin
      op_d = {1'b0, cmd_idx};
      case (cmd_idx)
        3'd0:    r_d = r_q + 32'd1;
        3'd1:    r_d = a_op + b_op;
        3'd2:    r_d = a_op - b_op;
        3'd3:    r_d = a_op & b_op;
        3'd4:    r_d = a_op | b_op;
        3'd5:    r_d = a_op ^ b_op;
        3'd6:    r_d = a_op << b_op[4:0];
        default: r_d = 32'd0;
      endcase
    end
  end

  // Result and last-op registers.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_q  <= 32'd0;
      op_q <= 4'd0;
    end else begin
      r_q  <= r_d;
      op_q <= op_d;
    end
  end

  assign led_light = ~r_q;

  // ---------------------------------------------------------------- UART transmit
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_dat_q, pend_dat_d;
  logic        tx_load;
  logic [39:0] tx_frame;
  tx_state_e   tx_state_q;
  logic        txd_q;
  logic [38:0] tx_shreg_q;
  logic [5:0]  tx_bit_q;
  logic [BCW-1:0] tx_baud_q;

  assign tx_load = (tx_state_q == TX_IDLE) && pend_vld_q;

  // Four 8N1 bytes, MSB byte first, laid out in line order from bit 0 upward.
  assign tx_frame = {1'b1, pend_dat_q[7:0],   1'b0,
                     1'b1, pend_dat_q[15:8],  1'b0,
                     1'b1, pend_dat_q[23:16], 1'b0,
                     1'b1, pend_dat_q[31:24], 1'b0};

  // One-deep request slot: consumed when the transmitter starts, overwritten by any new command.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    if (tx_load) pend_vld_d = 1'b0;
    if (cmd_vld) begin
      pend_vld_d = 1'b1;
      pend_dat_d = r_d;
    end
  end

  // Pending slot registers; reset drops any queued snapshot.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pend_vld_q <= 1'b0;
      pend_dat_q <= 32'd0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
    end
  end

  // Transmit FSM: shifts the 40-bit frame out, BAUD_DIV clocks per bit, line registered.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tx_state_q <= TX_IDLE;
      txd_q      <= 1'b1;
      tx_shreg_q <= '0;
      tx_bit_q   <= 6'd0;
      tx_baud_q  <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (pend_vld_q) begin
            tx_state_q <= TX_SEND;
            txd_q      <= tx_frame[0];
            tx_shreg_q <= tx_frame[39:1];
            tx_bit_q   <= 6'd0;
            tx_baud_q  <= '0;
          end
        end
        default: begin
          if (tx_baud_q == BCW'(BAUD_DIV - 1)) begin
            tx_baud_q <= '0;
            if (tx_bit_q == 6'd39) begin
              tx_state_q <= TX_IDLE;
              txd_q      <= 1'b1;
            end else begin
              txd_q      <= tx_shreg_q[0];
              tx_shreg_q <= {1'b0, tx_shreg_q[38:1]};
              tx_bit_q   <= tx_bit_q + 6'd1;
            end
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign uart_txd = txd_q;

  // ---------------------------------------------------------------- seven-segment display
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]     scan_idx;
  logic [3:0]     nib_lo, nib_hi;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Free-running scan counter; its top two bits are the digit index.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
  end

  // Scan counter register.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) scan_cnt_q <= '0;
    else           scan_cnt_q <= scan_cnt_d;
  end

  assign scan_idx = scan_cnt_q[SCW-1 -: 2];

  // Select the nibble of R for the active digit on both four-digit tubes.
  always_comb begin
    nib_lo = r_q[3:0];
    nib_hi = r_q[19:16];
    case (scan_idx)
      2'd1: begin nib_lo = r_q[7:4];   nib_hi = r_q[23:20]; end
      2'd2: begin nib_lo = r_q[11:8];  nib_hi = r_q[27:24]; end
      2'd3: begin nib_lo = r_q[15:12]; nib_hi = r_q[31:28]; end
      default: begin nib_lo = r_q[3:0]; nib_hi = r_q[19:16]; end
    endcase
  end

  assign digital_tube0     = hex7(nib_lo);
  assign digital_tube1     = hex7(nib_hi);
  assign digital_tube_sel0 = 4'b0001 << scan_idx;
  assign digital_tube_sel1 = 4'b0001 << scan_idx;
  assign digital_tube2     = hex7(op_q);
  assign digital_tube_sel2 = 1'b1;

endmodule

// File: tb/tb_mips_board_top.sv
`timescale 1ns/1ps
// Bench for mips_board_top: key-driven commands checked on LEDs/tubes, UART bytes against a scoreboard.
module tb_mips_board_top;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        uart_rxd;
  logic        uart_txd;
  logic [7:0]  dip0, dip1, dip2, dip3, dip4, dip5, dip6, dip7;
  logic [7:0]  user_key;
  logic [31:0] led_light;
  logic [7:0]  tube0, tube1, tube2;
  logic [3:0]  sel0, sel1;
  logic        sel2;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  exp_q [$];
  bit          mon_ignore = 1'b0;
  logic [31:0] model_r = 32'd0;
  logic [3:0]  model_op = 4'd0;
  logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0]  rx_byte;
  logic        rx_stop;
  logic [7:0]  rx_exp;

  always #5 clk = ~clk;

  mips_board_top dut (
    .clk_in(clk), .sys_rstn(sys_rstn), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .dip_switch0(dip0), .dip_switch1(dip1), .dip_switch2(dip2), .dip_switch3(dip3),
    .dip_switch4(dip4), .dip_switch5(dip5), .dip_switch6(dip6), .dip_switch7(dip7),
    .user_key(user_key), .led_light(led_light),
    .digital_tube0(tube0), .digital_tube1(tube1),
    .digital_tube_sel0(sel0), .digital_tube_sel1(sel1),
    .digital_tube2(tube2), .digital_tube_sel2(sel2)
  );

  // UART receiver: samples mid-bit on falling clock edges and pops the scoreboard per byte.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          rx_byte[i] = uart_txd;
        end
        repeat (BAUD) @(negedge clk);
        rx_stop = uart_txd;
        if (!mon_ignore) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL uart_unexpected: got byte %h, required none", rx_byte);
          end else begin
            rx_exp = exp_q.pop_front();
            if ({rx_stop, rx_byte} !== {1'b1, rx_exp}) begin
              tests_failed++;
              $display("FAIL uart_byte: got %h stop %b, required %h stop 1", rx_byte, rx_stop, rx_exp);
            end
          end
        end
      end
    end
  end

  // Reference command model; optionally pushes the expected 4-byte snapshot, MSB first.
  task automatic model_cmd(input logic [7:0] mask, input bit push);
    logic [31:0] a, b;
    int k;
    a = ~{dip3, dip2, dip1, dip0};
    b = ~{dip7, dip6, dip5, dip4};
    k = 0;
    for (int i = 7; i >= 0; i--) if (mask[i]) k = i;
    case (k)
      0: model_r = model_r + 32'd1;
      1: model_r = a + b;
      2: model_r = a - b;
      3: model_r = a & b;
      4: model_r = a | b;
      5: model_r = a ^ b;
      6: model_r = a << b[4:0];
      default: model_r = 32'd0;
    endcase
    model_op = 4'(k);
    if (push) for (int i = 3; i >= 0; i--) exp_q.push_back(model_r[8*i +: 8]);
  endtask

  task automatic press(input logic [7:0] mask, input bit push);
    @(negedge clk);
    user_key = ~mask;
    model_cmd(mask, push);
    repeat (10) @(negedge clk);
    user_key = 8'hFF;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL uart_drain: %0d bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0; uart_rxd = 1'b1; user_key = 8'hFF;
    {dip0, dip1, dip2, dip3, dip4, dip5, dip6, dip7} = {8{8'hFF}};
    #300;
    tests_run++; if (led_light !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL reset_led: got %h required ffffffff", led_light); end
    tests_run++; if (uart_txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b required 1", uart_txd); end
    tests_run++; if ({tube0, tube1, tube2} !== {3{8'hC0}}) begin tests_failed++; $display("FAIL reset_tubes: got %h %h %h required c0 c0 c0", tube0, tube1, tube2); end
    tests_run++; if ({sel0, sel1, sel2} !== {4'b0001, 4'b0001, 1'b1}) begin tests_failed++; $display("FAIL reset_sel: got %b %b %b required 0001 0001 1", sel0, sel1, sel2); end
    @(negedge clk);
    sys_rstn = 1'b1;
    model_r = 32'd0; model_op = 4'd0;
    repeat (20) @(negedge clk);
    tests_run++; if (led_light !== 32'hFFFFFFFF || uart_txd !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got led %h txd %b required ffffffff 1", led_light, uart_txd); end
  endtask

  task automatic test_key0_latency();
    logic [31:0] prev;
    int n;
    prev = model_r;
    @(negedge clk);
    user_key = 8'hFE;
    model_cmd(8'h01, 1'b1);
    repeat (6) @(negedge clk);
    tests_run++; if (led_light !== ~prev) begin tests_failed++; $display("FAIL key_early: got %h required %h", led_light, ~prev); end
    @(negedge clk);
    tests_run++; if (led_light !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL key_latency: got %h required fffffffe", led_light); end
    repeat (3) @(negedge clk);
    user_key = 8'hFF;
    repeat (10) @(negedge clk);
    n = 0;
    while (sel0 !== 4'b0001 && n < 100) begin @(negedge clk); n++; end
    tests_run++; if (sel0 !== 4'b0001 || tube0 !== 8'hF9 || tube1 !== 8'hC0 || tube2 !== 8'hC0) begin
      tests_failed++; $display("FAIL tube_digit0: got sel %b tubes %h %h %h required 0001 f9 c0 c0", sel0, tube0, tube1, tube2); end
  endtask

  task automatic test_back_to_back();
    press(8'h01, 1'b1);
    tests_run++; if (led_light !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL b2b_led: got %h required fffffffd", led_light); end
    wait_idle(3000);
  endtask

  task automatic test_glitch();
    bit seen_low = 1'b0;
    @(negedge clk);
    user_key = 8'hFE;
    repeat (2) @(negedge clk);
    user_key = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) seen_low = 1'b1;
    end
    tests_run++; if (led_light !== ~model_r) begin tests_failed++; $display("FAIL glitch_led: got %h required %h", led_light, ~model_r); end
    tests_run++; if (seen_low) begin tests_failed++; $display("FAIL glitch_txd: got line activity, required idle"); end
  endtask

  task automatic test_pending_overwrite();
    press(8'h01, 1'b1);
    press(8'h01, 1'b0);
    press(8'h01, 1'b1);
    tests_run++; if (led_light !== ~model_r) begin tests_failed++; $display("FAIL ovw_led: got %h required %h", led_light, ~model_r); end
    wait_idle(3000);
  endtask

  task automatic test_alu();
    int          keys  [7] = '{2, 6, 1, 3, 4, 5, 7};
    logic [31:0] exp_r [7] = '{32'h2, 32'h28, 32'h8, 32'h1, 32'h7, 32'h6, 32'h0};
    dip0 = 8'hFA; dip4 = 8'hFC;
    for (int i = 0; i < 7; i++) begin
      press(8'(1 << keys[i]), 1'b1);
      tests_run++; if (led_light !== ~exp_r[i]) begin tests_failed++; $display("FAIL alu_key%0d: got led %h required %h", keys[i], led_light, ~exp_r[i]); end
      tests_run++; if (tube2 !== glyph[keys[i]]) begin tests_failed++; $display("FAIL alu_op%0d: got tube2 %h required %h", keys[i], tube2, glyph[keys[i]]); end
      wait_idle(2000);
    end
    dip0 = 8'hFF; dip4 = 8'hFE;
    press(8'h04, 1'b1);
    tests_run++; if (led_light !== 32'h0) begin tests_failed++; $display("FAIL alu_wrap: got led %h required 00000000", led_light); end
    wait_idle(2000);
  endtask

  task automatic test_simultaneous();
    bit seen_low = 1'b0;
    dip0 = 8'hFA; dip4 = 8'hFC;
    press(8'h0A, 1'b1);
    tests_run++; if (led_light !== ~32'd8) begin tests_failed++; $display("FAIL simul_led: got %h required fffffff7", led_light); end
    tests_run++; if (tube2 !== 8'hF9) begin tests_failed++; $display("FAIL simul_op: got tube2 %h required f9", tube2); end
    wait_idle(2000);
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) seen_low = 1'b1;
    end
    tests_run++; if (seen_low) begin tests_failed++; $display("FAIL simul_frames: got a second frame, required one"); end
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    int n;
    prev = sel0; n = 0;
    while (sel0 === prev && n < 100) begin @(negedge clk); n++; end
    prev = sel0; n = 0;
    while (sel0 === prev && n < 100) begin @(negedge clk); n++; end
    tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL scan_period: got %0d clocks required 16", n); end
    tests_run++; if (sel0 !== {prev[2:0], prev[3]} || sel1 !== sel0) begin
      tests_failed++; $display("FAIL scan_rotate: got sel0 %b sel1 %b required %b", sel0, sel1, {prev[2:0], prev[3]}); end
  endtask

  task automatic test_reset_mid_tx();
    bit seen_low = 1'b0;
    int n = 0;
    mon_ignore = 1'b1;
    press(8'h01, 1'b0);
    press(8'h01, 1'b0);
    while (uart_txd !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    sys_rstn = 1'b0;
    #1;
    tests_run++; if (uart_txd !== 1'b1 || n >= 200) begin tests_failed++; $display("FAIL rst_abort: got txd %b after %0d clocks, required 1", uart_txd, n); end
    tests_run++; if (led_light !== 32'hFFFFFFFF || tube2 !== 8'hC0) begin tests_failed++; $display("FAIL rst_state: got led %h tube2 %h required ffffffff c0", led_light, tube2); end
    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;
    model_r = 32'd0; model_op = 4'd0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) seen_low = 1'b1;
    end
    tests_run++; if (seen_low) begin tests_failed++; $display("FAIL rst_pending: got frame after reset, required idle"); end
    mon_ignore = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key0_latency();
    test_back_to_back();
    test_glitch();
    test_pending_overwrite();
    test_alu();
    test_simultaneous();
    test_scan();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_board_top.md
# mips_board_top

Board-level top of the `mips` FPGA demo image. It reads eight active-low DIP-switch banks as two 32-bit operands and treats eight active-low push-keys as operation commands. The result is held in a 32-bit register `R`, shown on LEDs and three multiplexed seven-segment tubes, and sent over a UART transmitter. The block is self-contained: it sits directly on the board pins and has no bus.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required before a key level is accepted.
- `SCAN_BITS`, 4: tube digit advances every 2^SCAN_BITS clocks (use 16 on hardware).
- `BAUD_DIV`, 16: clocks per UART bit (use 868 for 115200 baud at 100 MHz).
- `clk_in` input 1: sole clock, rising edge.
- `sys_rstn` input 1: reset. It is asynchronous and active-low.
- `uart_rxd` input 1: unused; ignored entirely.
- `uart_txd` output 1: UART 8N1 transmit line, idle high.
- `dip_switch0`..`dip_switch7` input 8 each: active-low switches (8'hff means all off).
- `user_key` input 8: active-low push-keys, bit n is key n.
- `led_light` output 32: active-low LEDs.
- `digital_tube0`, `digital_tube1` output 8 each: segment lines, active-low, bit0=a … bit6=g, bit7=dp.
- `digital_tube_sel0`, `digital_tube_sel1` output 4 each: one-hot active-high digit select.
- `digital_tube2` output 8: segments of single-digit tube.
- `digital_tube_sel2` output 1: select of tube2, constant 1 out of reset.

## Operation
- Operands:
  - A = ~{dip_switch3, dip_switch2, dip_switch1, dip_switch0}.
  - B = ~{dip_switch7, …, dip_switch4}.
  - Both are sampled in the cycle the command executes.
- Keys:
  - Each bit has a 2-flop synchronizer followed by a debounce counter.
  - A press is a debounced 1→0 transition and yields a one-cycle command pulse.
  - Release generates nothing.
- Commands (32-bit, wrap-around, no flags):
  - key0: R←R+1
  - key1: R←A+B
  - key2: R←A−B
  - key3: R←A&B
  - key4: R←A|B
  - key5: R←A^B
  - key6: R←A<<B[4:0]
  - key7: R←0
- Simultaneous presses in the same cycle: lowest key index wins; the others are discarded.
- Register `OP` (4 bits) holds the index of the last executed command.
- Outputs:
  - led_light = ~R, combinational from R.
  - tube0 digits 0..3 show R[3:0], R[7:4], R[11:8], R[15:12]; sel bit i lights digit i.
  - tube1 shows R[31:16] in the same order.
  - tube2 shows OP as a hex digit.
  - Hex glyphs use the standard active-low encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E. The dp bit is always 1 (off).
- UART:
  - Every executed command requests transmission of a 4-byte snapshot of the new R, MSB byte first.
  - Each byte is framed as start 0, 8 data bits LSB first, stop 1.
  - If a request arrives while busy, it is stored in a one-deep pending slot; a newer request overwrites the pending one.
  - The pending frame starts the cycle after the current stop bit ends.

## Timing
- Reset (asynchronous, while sys_rstn=0):
  - R=0, OP=0.
  - Synchronizers, debounce state and key history all read "released".
  - led_light=32'hFFFFFFFF, uart_txd=1, no pending request.
  - Scan index 0, so sel0=sel1=4'b0001.
  - digital_tube0=digital_tube1=digital_tube2=8'hC0, sel2=1.
- Key latency:
  - A key falling edge updates R after 2 (sync) + DEBOUNCE_CYCLES + 1 clocks; that is 7 clocks at default.
  - Presses or releases shorter than DEBOUNCE_CYCLES samples are ignored.
- UART timing:
  - The start bit begins 1 clock after R updates.
  - Each bit lasts BAUD_DIV clocks; one 4-byte frame takes 40·BAUD_DIV clocks (640 at default).
- Scan: the digit index increments every 2^SCAN_BITS clocks and wraps 3→0.
- Reset mid-operation aborts a UART transmission immediately (line returns high) and clears the pending slot.

## Test plan
- Hold reset 300 ns, release with all inputs high → led_light=FFFFFFFF, uart_txd=1, tubes 8'hC0.
- Pull user_key=8'hFE for 100 ns at t=1000 ns:
  - 7 clocks after the falling edge, R=1 and led_light=FFFFFFFE.
  - tube0 digit0=F9.
  - UART sends 00 00 00 01.
- Second 100 ns key0 press at t=1600 ns while the UART is busy:
  - R=2, led_light=FFFFFFFD.
  - Bytes 00 00 00 02 follow the first frame back-to-back.
- Key0 low for only 2 clocks → no change to R or uart_txd.
- dip_switch0=8'hFA (A=5), dip_switch4=8'hFC (B=3):
  - key2 → R=2, OP=2.
  - key6 → R=0x28.
  - key7 → R=0.
  - With R=0, key2 on A=0, B=1 → R=FFFFFFFF (wrap), led_light=0.
- Keys 1 and 3 pressed in the same cycle → R=A+B only, OP=1, one UART frame.
